window_sum_buffer: RTL and testbench
====================================

Name: window_sum_buffer

Overview:
Parametrised sliding-window accumulator for pixel and sample streams. It keeps the last DEPTH accepted samples in a flop-based ring and outputs their exact sum. It updates the sum incrementally: add the new sample, subtract the evicted one. It adds sample-valid gating, a fill count, a window-full flag, synchronous flush, a full-width registered sum and a saturated narrow sum. It sits after the pixel source and feeds box-filter and averaging stages.

Parameters:
DATA_W, 12, sample width in bits (unsigned); legal range >= 1
DEPTH, 9, window length in samples; legal range >= 2
CNT_W, derived localparam = clog2(DEPTH+1), width of fill count
PTR_W, derived localparam = max(1, clog2(DEPTH)), ring pointer width
SUM_W, derived localparam = DATA_W + clog2(DEPTH), sum width; DEPTH*(2^DATA_W-1) always fits

Ports:
clk  in  1  rising-edge clock; one clock, no other clock domains
rst  in  1  reset; reset is asynchronous and active-low (asserted at 0)
en  in  1  sample valid; d_in is accepted on a rising clk edge when en=1
clr  in  1  synchronous flush; empties the window
d_in  in  DATA_W  unsigned input sample
d_out  out  SUM_W  registered exact sum of the samples currently in the window
d_sat  out  DATA_W  d_out saturated to 2^DATA_W-1
out_valid  out  1  high when the window holds DEPTH samples
fill  out  CNT_W  number of valid samples in the window, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous): ring entries, wr_ptr, fill, sum register and out_valid all go to 0. Therefore d_out=0 and d_sat=0. Deassertion takes effect at the first clk edge after rst=1.
- State: ring mem[0..DEPTH-1] of DATA_W, wr_ptr (0..DEPTH-1), fill, sum (SUM_W). All are flops; no RAM inference.
- Accept (en=1, clr=0) on a rising edge:
  - mem[wr_ptr] <= d_in.
  - sum <= sum + d_in - mem[wr_ptr], using the pre-edge value of mem[wr_ptr].
  - wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
  - fill <= min(fill+1, DEPTH).
  - out_valid <= (fill+1 >= DEPTH).
- Evicted entries before the first wrap are 0, so the partial-window sum is exact.
- Latency: the sum including a sample accepted at edge N is visible on d_out right after edge N (one register stage). There is no combinational path from d_in to d_out.
- Idle (en=0, clr=0): all state holds, and the outputs hold their values.
- clr=1: synchronous and same effect as reset at the edge. clr has priority over en; a simultaneous sample is dropped.
- Arithmetic: compute the add/subtract at SUM_W+1 bits. The result is never negative and never exceeds DEPTH*(2^DATA_W-1), so no wrap occurs.
- d_sat = (d_out > 2^DATA_W-1) ? all-ones : d_out[DATA_W-1:0]. It is combinational from the d_out register only.
- Fill and out_valid: fill saturates at DEPTH. out_valid stays high until reset or clr and never drops on en=0.
- Reset mid-stream: all history is lost and the window refills from empty. No partial state survives.
- d_in value is don't-care when en=0. X on d_in with en=0 must not propagate into any state.

Decomposition:
- Shared package/include: default DATA_W and DEPTH constants, and a clog2 constant function used for CNT_W, PTR_W and SUM_W.
- One natural sub-module: sample_ring.
  - Interface: clk, rst, wr_en, clr, wr_data, and the evicted-entry read old_data = mem[wr_ptr].
  - It owns the DEPTH x DATA_W flop ring and the wrap-around pointer.
- The top level holds the sum, fill and out_valid logic.

Test Plan:
1. Reset with DATA_W=12, DEPTH=9: drive rst=0 mid-clock -> d_out, d_sat, fill and out_valid go to 0 immediately. With rst=1 and en=0 they stay 0 for 5 cycles.
2. Fill: accept samples 1..9 on consecutive cycles -> d_out = 1,3,6,10,15,21,28,36,45 and fill = 1..9. out_valid goes to 1 only after the 9th sample.
3. Wrap and eviction: continue with 10,11 -> d_out=54 then 63. Apply 9 more samples of value 0 -> d_out reaches 0 after the ninth; out_valid stays 1.
4. Saturation and width: accept 9 samples of 4095 -> d_out=36855 (16 bits) and d_sat=4095. Accept 0 once -> d_out=32760, d_sat=4095.
5. Gaps and priority: interleave en=0 cycles with d_in=X -> outputs hold and no X appears. Assert clr together with en and d_in=7 -> all outputs 0. Next accept 5 -> d_out=5, fill=1.
6. Parametric: DEPTH=2, DATA_W=1 (SUM_W=2) and DEPTH=16, DATA_W=8 (SUM_W=12). Run random en/clr/rst for 10k cycles against a reference model -> exact d_out match. fill never exceeds DEPTH.

Source files
------------

// File: rtl/window_sum_buffer_pkg.sv
// -----------------------------------------------------------------------------
// window_sum_buffer_pkg
// Shared constants and helpers for the sliding-window sum buffer.
//   DATA_W_DEFAULT : default sample width in bits
//   DEPTH_DEFAULT  : default window length in samples
//   clog2()        : constant ceiling-log2 used to size counters, pointers, sums
// -----------------------------------------------------------------------------
package window_sum_buffer_pkg;

    localparam int unsigned DATA_W_DEFAULT = 12;
    localparam int unsigned DEPTH_DEFAULT  = 9;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/window_sum_buffer_sample_ring.sv
// -----------------------------------------------------------------------------
// sample_ring
// DEPTH x DATA_W flop ring with a wrap-around write pointer. The entry about to
// be overwritten is presented on old_data so the caller can subtract it.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset, clears ring and pointer
//   wr_en    : write wr_data at the pointer and advance it
//   clr      : synchronous flush, same effect as reset; wins over wr_en
//   wr_data  : sample to store
//   old_data : current contents of mem[wr_ptr] (the entry a write evicts)
// -----------------------------------------------------------------------------
module sample_ring
    import window_sum_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              clr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] old_data
);

    localparam int unsigned PTR_W = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (clr) begin
            mem_d    = '{default: '0};
            wr_ptr_d = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign old_data = mem_q[wr_ptr_q];

endmodule

// File: rtl/window_sum_buffer.sv
// -----------------------------------------------------------------------------
// window_sum_buffer
// Sliding-window accumulator: keeps the last DEPTH accepted samples and outputs
// their exact sum, updated incrementally (add new sample, subtract evicted one).
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   en        : sample valid, d_in accepted on a rising edge when high
//   clr       : synchronous flush of the window; has priority over en
//   d_in      : unsigned input sample
//   d_out     : registered exact window sum (SUM_W bits)
//   d_sat     : d_out saturated to 2**DATA_W-1
//   out_valid : window holds DEPTH samples (sticky until reset/clr)
//   fill      : number of valid samples, 0..DEPTH
// -----------------------------------------------------------------------------
module window_sum_buffer
    import window_sum_buffer_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEFAULT,
    parameter  int unsigned DEPTH  = DEPTH_DEFAULT,
    localparam int unsigned CNT_W  = clog2(DEPTH + 1),
    localparam int unsigned SUM_W  = DATA_W + clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] d_in,
    output logic [SUM_W-1:0]  d_out,
    output logic [DATA_W-1:0] d_sat,
    output logic              out_valid,
    output logic [CNT_W-1:0]  fill
);

    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(DEPTH);
    localparam logic [SUM_W-1:0] SAT_LIMIT = SUM_W'({DATA_W{1'b1}});

    logic [DATA_W-1:0] old_data;
    logic [SUM_W-1:0]  sum_q;
    logic [SUM_W-1:0]  sum_d;
    logic [CNT_W-1:0]  fill_q;
    logic [CNT_W-1:0]  fill_d;
    logic              out_valid_q;
    logic              out_valid_d;

    sample_ring #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sample_ring (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (en),
        .clr      (clr),
        .wr_data  (d_in),
        .old_data (old_data)
    );

    always_comb begin
        sum_d       = sum_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        if (clr) begin
            sum_d       = '0;
            fill_d      = '0;
            out_valid_d = 1'b0;
        end else if (en) begin
            // One guard bit keeps the intermediate add/subtract from wrapping;
            // ring slots not yet written hold 0, so partial windows stay exact.
            sum_d       = SUM_W'({1'b0, sum_q} + (SUM_W + 1)'(d_in)
                                 - (SUM_W + 1)'(old_data));
            fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + CNT_W'(1);
            out_valid_d = (({1'b0, fill_q} + (CNT_W + 1)'(1)) >= (CNT_W + 1)'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign d_out     = sum_q;
    assign fill      = fill_q;
    assign out_valid = out_valid_q;
    assign d_sat     = (sum_q > SAT_LIMIT) ? '1 : sum_q[DATA_W-1:0];

endmodule

// File: tb/tb_window_sum_buffer.sv
// -----------------------------------------------------------------------------
// tb_window_sum_buffer
// Three instances (12b/9, 1b/2, 8b/16) share one stimulus stream. Each has a
// queue model of the last DEPTH accepted samples checked every cycle; literal
// expectations on the 12b/9 instance pin the model for the directed sequence.
// -----------------------------------------------------------------------------
module tb_window_sum_buffer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [15:0] din;
    logic        chk_on;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d", name, act, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int unsigned DW = (g == 0) ? 12 : (g == 1) ? 1 : 8;
        localparam int unsigned DP = (g == 0) ? 9  : (g == 1) ? 2 : 16;
        localparam int unsigned SW = (g == 0) ? 16 : (g == 1) ? 2 : 12;
        localparam int unsigned CW = (g == 0) ? 4  : (g == 1) ? 2 : 5;

        logic [DW-1:0] d_in_g;
        logic [SW-1:0] d_out;
        logic [DW-1:0] d_sat;
        logic          out_valid;
        logic [CW-1:0] fill;

        assign d_in_g = din[DW-1:0];

        window_sum_buffer #(
            .DATA_W (DW),
            .DEPTH  (DP)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .clr       (clr),
            .d_in      (d_in_g),
            .d_out     (d_out),
            .d_sat     (d_sat),
            .out_valid (out_valid),
            .fill      (fill)
        );

        // Model: the window is literally the last DP accepted samples.
        int unsigned win[$];

        always @(posedge clk or negedge rst) begin
            if (!rst || clr) begin
                win.delete();
            end else if (en) begin
                win.push_back(int'(din[DW-1:0]));
                if (win.size() > DP) void'(win.pop_front());
            end
        end

        always @(negedge clk) begin
            if (chk_on) begin
                int unsigned s;
                int unsigned lim;
                s = 0;
                foreach (win[i]) s += win[i];
                lim = (1 << DW) - 1;
                check($sformatf("cfg%0d d_out", g), 32'(d_out), s);
                check($sformatf("cfg%0d d_sat", g), 32'(d_sat), (s > lim) ? lim : s);
                check($sformatf("cfg%0d fill", g), 32'(fill), 32'(win.size()));
                check($sformatf("cfg%0d out_valid", g), 32'(out_valid), 32'(win.size() == DP));
            end
        end
    end

    // Drive inputs just after a falling edge, return just after the next one.
    task automatic cyc(input logic e, input logic c, input logic [15:0] v);
        en  = e;
        clr = c;
        din = v;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        clr    = 1'b0;
        din    = '0;
        chk_on = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        rst    = 1'b1;
        chk_on = 1'b1;

        // Mid-clock asynchronous reset
        cyc(1'b1, 1'b0, 16'd5);
        cyc(1'b1, 1'b0, 16'd6);
        check("pre_reset d_out", 32'(cfg[0].d_out), 32'd11);
        #2 rst = 1'b0;
        #1;
        check("async_rst d_out", 32'(cfg[0].d_out), 32'd0);
        check("async_rst d_sat", 32'(cfg[0].d_sat), 32'd0);
        check("async_rst fill", 32'(cfg[0].fill), 32'd0);
        check("async_rst out_valid", 32'(cfg[0].out_valid), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 'x);
            check("idle_after_rst d_out", 32'(cfg[0].d_out), 32'd0);
        end

        // Fill 1..9
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b0, 16'(i));
            check("fill d_out", 32'(cfg[0].d_out), 32'(i * (i + 1) / 2));
            check("fill count", 32'(cfg[0].fill), 32'(i));
            check("fill out_valid", 32'(cfg[0].out_valid), 32'(i == 9));
        end

        // Wrap and eviction
        cyc(1'b1, 1'b0, 16'd10);
        check("wrap d_out 10", 32'(cfg[0].d_out), 32'd54);
        cyc(1'b1, 1'b0, 16'd11);
        check("wrap d_out 11", 32'(cfg[0].d_out), 32'd63);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, 16'd0);
            check("zeros out_valid", 32'(cfg[0].out_valid), 32'd1);
        end
        check("zeros d_out", 32'(cfg[0].d_out), 32'd0);

        // Saturation and full width
        cyc(1'b1, 1'b0, 16'd4095);
        check("sat one d_out", 32'(cfg[0].d_out), 32'd4095);
        check("sat one d_sat", 32'(cfg[0].d_sat), 32'd4095);
        cyc(1'b1, 1'b0, 16'd4095);
        check("sat two d_out", 32'(cfg[0].d_out), 32'd8190);
        check("sat two d_sat", 32'(cfg[0].d_sat), 32'd4095);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 16'd4095);
        check("sat max d_out", 32'(cfg[0].d_out), 32'd36855);
        check("sat max d_sat", 32'(cfg[0].d_sat), 32'd4095);
        cyc(1'b1, 1'b0, 16'd0);
        check("sat drop d_out", 32'(cfg[0].d_out), 32'd32760);
        check("sat drop d_sat", 32'(cfg[0].d_sat), 32'd4095);

        // Gaps with X on d_in, then clr priority over en
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 'x);
            check("gap d_out", 32'(cfg[0].d_out), 32'd32760);
            check("gap fill", 32'(cfg[0].fill), 32'd9);
        end
        cyc(1'b1, 1'b1, 16'd7);
        check("clr d_out", 32'(cfg[0].d_out), 32'd0);
        check("clr d_sat", 32'(cfg[0].d_sat), 32'd0);
        check("clr fill", 32'(cfg[0].fill), 32'd0);
        check("clr out_valid", 32'(cfg[0].out_valid), 32'd0);
        cyc(1'b1, 1'b0, 16'd5);
        check("post_clr d_out", 32'(cfg[0].d_out), 32'd5);
        check("post_clr d_sat", 32'(cfg[0].d_sat), 32'd5);
        check("post_clr fill", 32'(cfg[0].fill), 32'd1);
        check("post_clr out_valid", 32'(cfg[0].out_valid), 32'd0);

        // Random en/clr/rst against the queue models
        for (int n = 0; n < 10000; n++) begin
            logic e;
            rst = ($urandom_range(0, 299) != 0);
            e   = ($urandom_range(0, 3) != 0);
            if (e) begin
                cyc(1'b1, ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
            end else begin
                cyc(1'b0, ($urandom_range(0, 59) == 0), 'x);
            end
        end
        rst = 1'b1;
        cyc(1'b0, 1'b0, 'x);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
